pipeline_control: RTL

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_control.sv
// Five-stage pipeline controller: generates PC/stage-buffer load enables and
// per-stage valid bits, handling data-memory stalls, load-use hazards, taken
// branch flushes, and instruction-fetch waits.
// Optional feature: define PIPE_STALL_COUNT_EN to add the 16-bit saturating
// stall_cycles counter port.
module pipeline_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       imem_resp,
  input  logic       dmem_req,
  input  logic       dmem_resp,
  input  logic       mem_br_taken,
  input  logic [2:0] id_src1,
  input  logic [2:0] id_src2,
  input  logic       id_uses_src1,
  input  logic       id_uses_src2,
  input  logic [2:0] ex_dest,
  input  logic       ex_is_load,
  input  logic       ex_writes_reg,
  output logic       imem_read,
  output logic       pc_load,
  output logic       load_if_id,
  output logic       load_id_ex,
  output logic       load_ex_mem,
  output logic       load_mem_wb,
`ifdef PIPE_STALL_COUNT_EN
  output logic [15:0] stall_cycles,
`endif
  output logic       valid_id,
  output logic       valid_ex,
  output logic       valid_mem,
  output logic       valid_wb
);

  typedef enum logic [1:0] {StInit, StRun, StDstall, StFdrain} state_e;

  state_e state_q, state_d;
  logic   valid_id_q, valid_id_d;
  logic   valid_ex_q, valid_ex_d;
  logic   valid_mem_q, valid_mem_d;
  logic   valid_wb_q, valid_wb_d;

  logic dmem_wait;
  logic flush;
  logic hazard;

  assign dmem_wait = valid_mem_q & dmem_req & ~dmem_resp;
  assign flush     = valid_mem_q & mem_br_taken;
  assign hazard    = valid_id_q & valid_ex_q & ex_is_load & ex_writes_reg &
                     ((id_uses_src1 & (id_src1 == ex_dest)) |
                      (id_uses_src2 & (id_src2 == ex_dest)));

  assign valid_id  = valid_id_q;
  assign valid_ex  = valid_ex_q;
  assign valid_mem = valid_mem_q;
  assign valid_wb  = valid_wb_q;

  // State and stage-valid registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      valid_id_q  <= 1'b0;
      valid_ex_q  <= 1'b0;
      valid_mem_q <= 1'b0;
      valid_wb_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_id_q  <= valid_id_d;
      valid_ex_q  <= valid_ex_d;
      valid_mem_q <= valid_mem_d;
      valid_wb_q  <= valid_wb_d;
    end
  end

  // Next state, load enables and next valid bits; events resolved in priority order.
  always_comb begin
    state_d     = state_q;
    imem_read   = 1'b0;
    pc_load     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    valid_id_d  = valid_id_q;
    valid_ex_d  = valid_ex_q;
    valid_mem_d = valid_mem_q;
    valid_wb_d  = valid_wb_q;

    case (state_q)
      StInit: begin
        state_d = StRun;
      end

      // DSTALL evaluates the same rules so the pipeline resumes in the
      // cycle the data response arrives.
      StRun, StDstall: begin
        imem_read = (state_q == StRun);
        if (dmem_wait) begin
          state_d = StDstall;
        end else if (flush) begin
          pc_load     = 1'b1;
          load_if_id  = 1'b1;
          load_id_ex  = 1'b1;
          load_ex_mem = 1'b1;
          load_mem_wb = 1'b1;
          valid_id_d  = 1'b0;
          valid_ex_d  = 1'b0;
          valid_mem_d = 1'b0;
          valid_wb_d  = 1'b0;
          // An unanswered fetch is for the wrong path; drain it first.
          state_d     = imem_resp ? StRun : StFdrain;
        end else if (hazard) begin
          load_id_ex  = 1'b1;
          load_ex_mem = 1'b1;
          load_mem_wb = 1'b1;
          valid_ex_d  = 1'b0;
          valid_mem_d = valid_ex_q;
          valid_wb_d  = valid_mem_q;
          state_d     = StRun;
        end else if (!imem_resp) begin
          load_if_id  = 1'b1;
          load_id_ex  = 1'b1;
          load_ex_mem = 1'b1;
          load_mem_wb = 1'b1;
          valid_id_d  = 1'b0;
          valid_ex_d  = valid_id_q;
          valid_mem_d = valid_ex_q;
          valid_wb_d  = valid_mem_q;
          state_d     = StRun;
        end else begin
          pc_load     = 1'b1;
          load_if_id  = 1'b1;
          load_id_ex  = 1'b1;
          load_ex_mem = 1'b1;
          load_mem_wb = 1'b1;
          valid_id_d  = 1'b1;
          valid_ex_d  = valid_id_q;
          valid_mem_d = valid_ex_q;
          valid_wb_d  = valid_mem_q;
          state_d     = StRun;
        end
      end

      // Stale fetch in flight: keep the pipe moving, discard the returned word.
      StFdrain: begin
        imem_read   = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        valid_id_d  = 1'b0;
        valid_ex_d  = valid_id_q;
        valid_mem_d = valid_ex_q;
        valid_wb_d  = valid_mem_q;
        if (imem_resp) begin
          state_d = StRun;
        end
      end

      default: begin
        state_d = StInit;
      end
    endcase
  end

`ifdef PIPE_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  assign stall_cycles = stall_cnt_q;

  // Saturating count of non-INIT cycles in which the PC is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
    end else if ((state_q != StInit) && !pc_load && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
`endif

endmodule
